// File: rtl/shifter_left_seq.sv
// Multi-cycle logical left shifter for SLL/SLLI.
// Resolves one barrel stage per clock, MSB stage first.
module shifter_left_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [SHW-1:0]   inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [SHW-1:0] STAGE_TOP = SHW'(SHW - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] shifted;
    logic [SHW-1:0]   amt, amt_nxt;
    logic [SHW-1:0]   stage, stage_nxt;
    logic             done_nxt;

    // One barrel stage: shift by 2^stage when that amount bit is set
    always_comb begin
        shifted = acc;
        if (amt[stage]) begin
            shifted = acc << (1 << stage);
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        amt_nxt   = amt;
        stage_nxt = stage;
        out_nxt   = out;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt   = inA;
                    amt_nxt   = inB;
                    stage_nxt = STAGE_TOP;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                acc_nxt = shifted;
                if (stage != '0) begin
                    stage_nxt = stage - 1'b1;
                end else begin
                    out_nxt   = shifted;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            amt   <= '0;
            stage <= STAGE_TOP;
            out   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            amt   <= amt_nxt;
            stage <= stage_nxt;
            out   <= out_nxt;
            done  <= done_nxt;
        end
    end

    // Busy decoded from the state register
    always_comb begin
        busy = (state == SHIFT);
    end

endmodule

// File: tb/tb_shifter_left_seq.sv
// Testbench for shifter_left_seq.
// Cycle-count model plus directed literal checks.
module tb_shifter_left_seq;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] inA;
    logic [SHW-1:0]   inB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    // model state: cycles left, pending result, visible outputs
    int               m_cnt = 0;
    logic [WIDTH-1:0] m_res = '0;
    logic [WIDTH-1:0] m_out = '0;
    logic             m_done = 1'b0;

    shifter_left_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .inA   (inA),
        .inB   (inB),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: result appears SHW+1 edges after an accepted start
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_cnt <= 0;
            m_out <= '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt <= SHW;
                m_res <= inA << inB;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_out  <= m_res;
                m_done <= 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_cnt > 0});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("out", out, m_out);
        end
    end

    // Issue one op from just after a negedge; return in the done cycle
    task automatic op(input logic [31:0] a, input logic [4:0] b,
                      input logic [31:0] lit, input bit scramble,
                      input string name);
        int n;
        int nb;
        bit seen;
        n = 0;
        nb = 0;
        seen = 1'b0;
        start = 1'b1;
        inA = a;
        inB = b;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (scramble) begin
                inA = $urandom;
                inB = 5'($urandom_range(0, 31));
            end
            if (busy) nb++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            nvec++;
            nerr++;
            $display("FAIL %s_timeout: got no done, expected done", name);
        end else begin
            chk({name, "_lat"}, n, 6);
            chk({name, "_busy"}, nb, 5);
            chk({name, "_out"}, out, lit);
            chk({name, "_model"}, m_out, lit);
        end
    endtask

    initial begin
        int nd;
        rst = 1'b1;
        start = 1'b0;
        inA = '0;
        inB = '0;
        repeat (2) @(negedge clk);
        chk("rst_out", out, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        op(32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, "full");
        @(negedge clk);
        op(32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, "zero");
        @(negedge clk);
        op(32'h1234_5678, 5'd4, 32'h2345_6780, 1'b0, "sh4");
        @(negedge clk);
        op(32'hFFFF_FFFF, 5'd21, 32'hFFE0_0000, 1'b0, "sh21");
        @(negedge clk);

        // start while busy is ignored
        start = 1'b1;
        inA = 32'h0000_000F;
        inB = 5'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        inA = 32'hAAAA_AAAA;
        inB = 5'd8;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("busy_ign_out", out, 32'h0000_001E);
        chk("busy_ign_done", nd, 1);

        // back-to-back: second start issued in the done cycle
        op(32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, "b2b_a");
        op(32'h0000_00F0, 5'd8, 32'h0000_F000, 1'b0, "b2b_b");
        @(negedge clk);

        // reset mid-operation
        start = 1'b1;
        inA = 32'h0000_0001;
        inB = 5'd31;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_out", out, 32'h0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_nodone", nd, 0);
        op(32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, "post_rst");
        @(negedge clk);

        // inputs scrambled every cycle after the start edge
        op(32'h0F0F_0F0F, 5'd3, 32'h7878_7878, 1'b1, "hold");
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
